// File: rtl/debug_mon_pkg.sv
// Shared types and JTAG field positions for the debug monitor.
// Optional feature macro: MON_ADDR_AUTOINC_EN.
package debug_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } mon_state_e;

  localparam int JDO_W          = 38;
  localparam int JDO_RD_BIT     = 35;
  localparam int JDO_CLRERR_BIT = 36;
  localparam int JDO_ADDR_LSB   = 17;
  localparam int JDO_WDATA_LSB  = 3;

  localparam int DEF_TIMEOUT_CYCLES = 255;
  localparam int DEF_TO_W           = 8;

endpackage

// File: rtl/debug_mon_timeout.sv
// Saturating stall counter; expire_o flags the cycle that hits LIMIT.
// Optional feature macro: MON_ADDR_AUTOINC_EN (not used here).
module debug_mon_timeout #(
  parameter int TO_W  = 8,
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam logic [TO_W-1:0] LAST = TO_W'(LIMIT - 1);
  localparam logic [TO_W-1:0] MAX  = '1;

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = inc_i & ~clr_i & (cnt_q >= LAST);

endmodule

// File: rtl/debug_mon_mem_access.sv
// Debug monitor: runs JTAG-decoded single-word Avalon-MM accesses.
// Optional feature macro: MON_ADDR_AUTOINC_EN (address post-increment).
module debug_mon_mem_access
  import debug_mon_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TO_W           = DEF_TO_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  mon_state_e        state_q;
  logic [ADDR_W-1:0] mon_a_q;
  logic [31:0]       mon_d_q;
  logic [31:0]       wdata_q;
  logic              ready_q;
  logic              error_q;

  logic busy, any_take, ack, expire;
  logic cmd_wr, cmd_ld, cmd_rd;
  logic unused_jdo;

  assign busy     = (state_q != IDLE);
  assign any_take = take_action_ocimem_a
                  | take_no_action_ocimem_a
                  | take_action_ocimem_b;
  assign ack      = busy & ~avm_waitrequest;

  // One-hot command select with b > a > no_action priority
  assign cmd_wr = take_action_ocimem_b;
  assign cmd_ld = take_action_ocimem_a & ~take_action_ocimem_b;
  assign cmd_rd = take_no_action_ocimem_a
                & ~take_action_ocimem_a
                & ~take_action_ocimem_b;

  assign unused_jdo = ^{jdo[JDO_W-1], jdo[JDO_WDATA_LSB-1:0]};

  debug_mon_timeout #(
    .TO_W  (TO_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .clr_i    (~busy),
    .inc_i    (busy & avm_waitrequest),
    .expire_o (expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mon_a_q <= '0;
      mon_d_q <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          unique case (1'b1)
            cmd_wr: begin
              wdata_q <= jdo[JDO_WDATA_LSB +: 32];
              mon_d_q <= jdo[JDO_WDATA_LSB +: 32];
              ready_q <= 1'b0;
              state_q <= WR;
            end
            cmd_ld: begin
              mon_a_q <= jdo[JDO_ADDR_LSB +: ADDR_W];
              if (jdo[JDO_CLRERR_BIT]) error_q <= 1'b0;
              if (jdo[JDO_RD_BIT]) begin
                ready_q <= 1'b0;
                state_q <= RD;
              end else begin
                ready_q <= 1'b1;
              end
            end
            cmd_rd: begin
              ready_q <= 1'b0;
              state_q <= RD;
            end
            default: ;
          endcase
        end
        RD, WR: begin
          if (any_take) error_q <= 1'b1;
          if (ack) begin
            if (state_q == RD) mon_d_q <= avm_readdata;
`ifdef MON_ADDR_AUTOINC_EN
            mon_a_q <= mon_a_q + 1'b1;
`endif
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else if (expire) begin
            error_q <= 1'b1;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign avm_address   = mon_a_q;
  assign avm_read      = (state_q == RD);
  assign avm_write     = (state_q == WR);
  assign avm_writedata = wdata_q;
  assign MonDReg       = mon_d_q;
  assign MonAReg       = mon_a_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

endmodule

// File: tb/tb_debug_mon_mem_access.sv
// Scoreboard bench for debug_mon_mem_access (TIMEOUT_CYCLES=8).
// Honours MON_ADDR_AUTOINC_EN in its address model.
module tb_debug_mon_mem_access;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [37:0] jdo = '0;
  logic        take_a = 1'b0;
  logic        take_na = 1'b0;
  logic        take_b = 1'b0;
  logic [15:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = '0;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] MonDReg;
  logic [15:0] MonAReg;
  logic        monitor_ready;
  logic        monitor_error;

  int nvec = 0;
  int nerr = 0;
  txn_t exp_q[$];
  txn_t obs_q[$];
  logic [15:0] m_addr;

  always #5 clk = ~clk;

  debug_mon_mem_access #(
    .ADDR_W         (16),
    .TIMEOUT_CYCLES (8),
    .TO_W           (8)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_no_action_ocimem_a (take_na),
    .take_action_ocimem_b    (take_b),
    .avm_address             (avm_address),
    .avm_read                (avm_read),
    .avm_write               (avm_write),
    .avm_writedata           (avm_writedata),
    .avm_readdata            (avm_readdata),
    .avm_waitrequest         (avm_waitrequest),
    .MonDReg                 (MonDReg),
    .MonAReg                 (MonAReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  function automatic logic [15:0] next_addr(input logic [15:0] a);
`ifdef MON_ADDR_AUTOINC_EN
    return a + 16'd1;
`else
    return a;
`endif
  endfunction

  function automatic logic [37:0] jdo_a(input logic [15:0] a,
                                       input logic rd,
                                       input logic clr);
    logic [37:0] j;
    j = '0;
    j[32:17] = a;
    j[35] = rd;
    j[36] = clr;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic pulse(input logic a, input logic na,
                       input logic b, input logic [37:0] j);
    jdo = j;
    take_a = a;
    take_na = na;
    take_b = b;
    @(posedge clk);
    @(negedge clk);
    take_a = 1'b0;
    take_na = 1'b0;
    take_b = 1'b0;
  endtask

  // Slave model: stall for 'waits' strobe cycles, then complete
  task automatic run_bus(input int waits, input logic [31:0] rdata,
                         output int strobes, output int lat,
                         output bit tmo);
    int seen;
    txn_t t;
    seen = 0;
    strobes = 0;
    lat = 0;
    tmo = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (avm_read || avm_write) begin
        strobes++;
        avm_waitrequest = (seen < waits);
        avm_readdata = avm_waitrequest ? 32'h0BAD0BAD : rdata;
        seen++;
        if (!avm_waitrequest) begin
          t.wr = avm_write;
          t.addr = avm_address;
          t.data = avm_write ? avm_writedata : rdata;
          obs_q.push_back(t);
        end
      end else begin
        avm_waitrequest = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (monitor_ready) begin
        tmo = 1'b0;
        break;
      end
    end
    avm_waitrequest = 1'b0;
  endtask

  task automatic test_reset;
    #3 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    nvec++;
    if ({avm_read, avm_write, monitor_ready, monitor_error} !== 4'b0) begin
      nerr++;
      $display("FAIL reset_flags: got %b want 0000",
               {avm_read, avm_write, monitor_ready, monitor_error});
    end
    nvec++;
    if ({MonDReg, MonAReg, avm_writedata, avm_address} !== '0) begin
      nerr++;
      $display("FAIL reset_regs: got d=%h a=%h wd=%h ad=%h want 0",
               MonDReg, MonAReg, avm_writedata, avm_address);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_addr_load;
    pulse(1'b1, 1'b0, 1'b0, jdo_a(16'h0010, 1'b0, 1'b0));
    m_addr = 16'h0010;
    nvec++;
    if (MonAReg !== m_addr) begin
      nerr++;
      $display("FAIL load_addr: got %h want %h", MonAReg, m_addr);
    end
    nvec++;
    if ({avm_read, monitor_ready} !== 2'b01) begin
      nerr++;
      $display("FAIL load_flags: got rd/rdy %b want 01",
               {avm_read, monitor_ready});
    end
    @(negedge clk);
    nvec++;
    if (avm_read !== 1'b0) begin
      nerr++;
      $display("FAIL load_noread: got %b want 0", avm_read);
    end
  endtask

  task automatic test_read;
    int st, lat;
    bit tmo;
    txn_t got, want;
    exp_q.push_back('{1'b0, m_addr, 32'hDEADBEEF});
    pulse(1'b0, 1'b1, 1'b0, '0);
    run_bus(3, 32'hDEADBEEF, st, lat, tmo);
    m_addr = next_addr(m_addr);
    want = exp_q.pop_front();
    got = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL read_txn: got %h want %h", got, want);
    end
    nvec++;
    if ({tmo, st, lat} !== {1'b0, 32'd4, 32'd4}) begin
      nerr++;
      $display("FAIL read_timing: got tmo=%0b strobes=%0d lat=%0d want 0/4/4",
               tmo, st, lat);
    end
    nvec++;
    if (MonDReg !== 32'hDEADBEEF) begin
      nerr++;
      $display("FAIL read_dreg: got %h want deadbeef", MonDReg);
    end
    nvec++;
    if (MonAReg !== m_addr) begin
      nerr++;
      $display("FAIL read_areg: got %h want %h", MonAReg, m_addr);
    end
    nvec++;
    if ({avm_read, monitor_error} !== 2'b00) begin
      nerr++;
      $display("FAIL read_after: got rd/err %b want 00",
               {avm_read, monitor_error});
    end
  endtask

  task automatic test_write_wrap;
    int st, lat;
    bit tmo;
    txn_t got, want;
    pulse(1'b1, 1'b0, 1'b0, jdo_a(16'hFFFF, 1'b0, 1'b0));
    m_addr = 16'hFFFF;
    exp_q.push_back('{1'b1, 16'hFFFF, 32'h12345678});
    pulse(1'b0, 1'b0, 1'b1, jdo_b(32'h12345678));
    run_bus(0, 32'h0, st, lat, tmo);
    m_addr = next_addr(m_addr);
    want = exp_q.pop_front();
    got = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL write_txn: got %h want %h", got, want);
    end
    nvec++;
    if ({tmo, st, lat} !== {1'b0, 32'd1, 32'd1}) begin
      nerr++;
      $display("FAIL write_timing: got tmo=%0b strobes=%0d lat=%0d want 0/1/1",
               tmo, st, lat);
    end
    nvec++;
    if ({MonAReg, MonDReg} !== {m_addr, 32'h12345678}) begin
      nerr++;
      $display("FAIL write_regs: got a=%h d=%h want a=%h d=12345678",
               MonAReg, MonDReg, m_addr);
    end
    nvec++;
    if ({avm_write, monitor_error} !== 2'b00) begin
      nerr++;
      $display("FAIL write_after: got wr/err %b want 00",
               {avm_write, monitor_error});
    end
  endtask

  task automatic test_timeout;
    int st, lat;
    bit tmo;
    pulse(1'b1, 1'b0, 1'b0, jdo_a(16'h0040, 1'b0, 1'b0));
    m_addr = 16'h0040;
    pulse(1'b0, 1'b1, 1'b0, '0);
    run_bus(1000, 32'h0, st, lat, tmo);
    nvec++;
    if ({tmo, st} !== {1'b0, 32'd8}) begin
      nerr++;
      $display("FAIL tmo_strobes: got tmo=%0b strobes=%0d want 0/8", tmo, st);
    end
    nvec++;
    if ({monitor_error, monitor_ready, avm_read} !== 3'b110) begin
      nerr++;
      $display("FAIL tmo_flags: got err/rdy/rd %b want 110",
               {monitor_error, monitor_ready, avm_read});
    end
    nvec++;
    if ({MonDReg, MonAReg} !== {32'h12345678, m_addr}) begin
      nerr++;
      $display("FAIL tmo_regs: got d=%h a=%h want d=12345678 a=%h",
               MonDReg, MonAReg, m_addr);
    end
    nvec++;
    if (obs_q.size() != 0) begin
      nerr++;
      $display("FAIL tmo_nobus: got %0d txns want 0", obs_q.size());
      obs_q.delete();
    end
    pulse(1'b1, 1'b0, 1'b0, jdo_a(16'h0040, 1'b0, 1'b1));
    nvec++;
    if ({monitor_error, monitor_ready} !== 2'b01) begin
      nerr++;
      $display("FAIL tmo_clear: got err/rdy %b want 01",
               {monitor_error, monitor_ready});
    end
  endtask

  task automatic test_overrun;
    int st, lat;
    bit tmo;
    txn_t got, want;
    exp_q.push_back('{1'b0, m_addr, 32'h55AA55AA});
    pulse(1'b0, 1'b1, 1'b0, '0);
    avm_waitrequest = 1'b1;
    pulse(1'b0, 1'b0, 1'b1, jdo_b(32'hCAFEF00D));
    run_bus(0, 32'h55AA55AA, st, lat, tmo);
    m_addr = next_addr(m_addr);
    want = exp_q.pop_front();
    got = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL ovr_txn: got %h want %h", got, want);
    end
    nvec++;
    if ({tmo, monitor_error, MonDReg} !== {2'b01, 32'h55AA55AA}) begin
      nerr++;
      $display("FAIL ovr_state: got tmo=%0b err=%0b d=%h want 0/1/55aa55aa",
               tmo, monitor_error, MonDReg);
    end
    nvec++;
    if (avm_writedata !== 32'h12345678) begin
      nerr++;
      $display("FAIL ovr_wdata: got %h want 12345678", avm_writedata);
    end
  endtask

  task automatic test_priority;
    int st, lat;
    bit tmo;
    logic [37:0] j;
    logic [31:0] d;
    txn_t got, want;
    j = '0;
    j[34:3] = 32'hA5C30F96;
    j[35] = 1'b1;
    j[36] = 1'b1;
    d = j[34:3];
    exp_q.push_back('{1'b1, m_addr, d});
    pulse(1'b1, 1'b1, 1'b1, j);
    run_bus(1, 32'h0, st, lat, tmo);
    m_addr = next_addr(m_addr);
    want = exp_q.pop_front();
    got = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL prio_txn: got %h want %h", got, want);
    end
    nvec++;
    if ({tmo, lat, MonAReg, MonDReg} !== {1'b0, 32'd2, m_addr, d}) begin
      nerr++;
      $display("FAIL prio_regs: got tmo=%0b lat=%0d a=%h d=%h want 0/2/%h/%h",
               tmo, lat, MonAReg, MonDReg, m_addr, d);
    end
    nvec++;
    if (monitor_error !== 1'b1) begin
      nerr++;
      $display("FAIL prio_err_kept: got %b want 1", monitor_error);
    end
    pulse(1'b1, 1'b0, 1'b0, jdo_a(m_addr, 1'b0, 1'b1));
  endtask

  task automatic test_back_to_back;
    int st, lat, w;
    bit tmo;
    logic [31:0] d;
    txn_t got, want;
    for (int i = 0; i < 6; i++) begin
      w = $urandom_range(0, 4);
      d = $urandom;
      exp_q.push_back('{1'b0, m_addr, d});
      pulse(1'b0, 1'b1, 1'b0, '0);
      run_bus(w, d, st, lat, tmo);
      m_addr = next_addr(m_addr);
      want = exp_q.pop_front();
      got = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
      nvec++;
      if (got !== want) begin
        nerr++;
        $display("FAIL b2b_txn[%0d]: got %h want %h", i, got, want);
      end
      nvec++;
      if ({tmo, lat, MonDReg, MonAReg} !== {1'b0, w + 1, d, m_addr}) begin
        nerr++;
        $display("FAIL b2b_res[%0d]: got tmo=%0b lat=%0d d=%h a=%h want 0/%0d/%h/%h",
                 i, tmo, lat, MonDReg, MonAReg, w + 1, d, m_addr);
      end
    end
  endtask

  task automatic test_reset_mid;
    pulse(1'b0, 1'b1, 1'b0, '0);
    avm_waitrequest = 1'b1;
    @(posedge clk);
    @(negedge clk);
    nvec++;
    if (avm_read !== 1'b1) begin
      nerr++;
      $display("FAIL rstmid_pre: got rd=%b want 1", avm_read);
    end
    #2 reset_n = 1'b0;
    #1;
    nvec++;
    if ({avm_read, avm_write, monitor_ready, monitor_error,
         MonDReg, MonAReg, avm_writedata} !== '0) begin
      nerr++;
      $display("FAIL rstmid_async: got rd=%b d=%h a=%h rdy=%b want all 0",
               avm_read, MonDReg, MonAReg, monitor_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    avm_waitrequest = 1'b0;
    @(posedge clk);
    @(negedge clk);
    nvec++;
    if ({avm_read, avm_write, monitor_ready} !== 3'b000) begin
      nerr++;
      $display("FAIL rstmid_after: got rd/wr/rdy %b want 000",
               {avm_read, avm_write, monitor_ready});
    end
  endtask

  initial begin
    test_reset();
    test_addr_load();
    test_read();
    test_write_wrap();
    test_timeout();
    test_overrun();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/debug_mon_mem_access.md
Name: debug_mon_mem_access

Overview:
- Clock-domain consumer of the debug slave's decoded JTAG commands (jdo, take_action_ocimem_a/b, take_no_action_ocimem_a).
- Runs single-word read/write accesses on a debug Avalon-MM master port.
- Returns MonDReg, monitor_ready and monitor_error, which feed straight back into the debug slave wrapper's inputs for scan-out.

Parameters:
ADDR_W, 16, word-address width of MonAReg and avm_address
TIMEOUT_CYCLES, 255, max cycles waitrequest may stall one access before abort (1..2^TO_W-1)
TO_W, 8, timeout counter width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
jdo  in  38  JTAG data-out word, stable while any take_* pulse is high
take_action_ocimem_a  in  1  one-cycle pulse: load address / optional read
take_no_action_ocimem_a  in  1  one-cycle pulse: read at current address
take_action_ocimem_b  in  1  one-cycle pulse: write jdo[34:3] at current address
avm_address  out  ADDR_W  word address
avm_read  out  1  read strobe
avm_write  out  1  write strobe
avm_writedata  out  32  write data
avm_readdata  in  32  read data, valid in the cycle read is high and waitrequest is low
avm_waitrequest  in  1  slave stall
MonDReg  out  32  monitor data register
MonAReg  out  ADDR_W  monitor address register
monitor_ready  out  1  last command complete
monitor_error  out  1  sticky error: timeout or command overrun

Behaviour:
- Reset, asynchronous: all outputs 0, state IDLE, timeout counter 0.
- States: IDLE, RD, WR.
- Commands are accepted only in IDLE. Priority when several pulses coincide: b > a > no_action_a. The lower-priority pulses are discarded without error.
- take_action_ocimem_a in IDLE:
  - MonAReg <= jdo[ADDR_W+16:17].
  - If jdo[35]=1, go to RD next cycle and drop monitor_ready; else stay IDLE with monitor_ready=1.
- take_no_action_ocimem_a in IDLE: go to RD and drop monitor_ready.
- take_action_ocimem_b in IDLE:
  - avm_writedata <= jdo[34:3].
  - MonDReg <= jdo[34:3].
  - Go to WR and drop monitor_ready.
- RD:
  - avm_read=1 and avm_address=MonAReg, held while waitrequest=1.
  - On the first cycle with waitrequest=0: MonDReg <= avm_readdata; MonAReg post-increments; monitor_ready <= 1; return to IDLE.
  - avm_read deasserts the following cycle.
- WR: same as RD with avm_write. MonDReg is unchanged on completion.
- Minimum latency, pulse to monitor_ready=1: 2 cycles (accept cycle plus one zero-wait bus cycle).
- Timeout:
  - Counter clears on entry to RD/WR and increments on every cycle with waitrequest=1.
  - When it reaches TIMEOUT_CYCLES: drop the strobe, set monitor_error=1, set monitor_ready=1, return to IDLE.
  - MonDReg and MonAReg are unchanged.
- Overrun: any take_* pulse while in RD/WR is ignored and sets monitor_error=1.
- monitor_error clears only when a take_action_ocimem_a with jdo[36]=1 is accepted, or on reset.
- Address wrap: MonAReg increments modulo 2^ADDR_W, so all-ones wraps to 0 with no error.
- Reset asserted mid-access: strobes drop immediately (asynchronous). No completion is reported.

Optional Feature:
- Macro MON_ADDR_AUTOINC_EN.
- Defined: MonAReg post-increments after each successful RD/WR.
- Undefined: MonAReg changes only on take_action_ocimem_a. The increment logic is absent.

Decomposition:
- Package debug_mon_pkg:
  - state enum (IDLE, RD, WR)
  - jdo field constants: JDO_RD_BIT=35, JDO_CLRERR_BIT=36, JDO_ADDR_LSB=17, JDO_WDATA_LSB=3
  - default TIMEOUT_CYCLES
- One sub-module, debug_mon_timeout: loadable saturating counter with an expiry flag, parameterised by TO_W.

Test Plan:
- Address load: take_action_ocimem_a with jdo[32:17]=0x0010, jdo[35]=0 → MonAReg=0x0010, no avm_read, monitor_ready=1.
- Read: take_no_action_ocimem_a with slave returning 0xDEADBEEF after 3 waitrequest cycles → avm_read high for 4 cycles, MonDReg=0xDEADBEEF, MonAReg=0x0011, monitor_ready rises 5 cycles after the pulse.
- Write at wrap: MonAReg=0xFFFF, take_action_ocimem_b with jdo[34:3]=0x12345678, zero wait → avm_write for 1 cycle with avm_address=0xFFFF and avm_writedata=0x12345678, then MonAReg=0x0000.
- Timeout: waitrequest held high with TIMEOUT_CYCLES=8 → strobe drops after 8 cycles, monitor_error=1, MonDReg unchanged. A later take_action_ocimem_a with jdo[36]=1 clears monitor_error.
- Overrun/priority:
  - take_action_ocimem_b pulsed during RD → ignored, monitor_error=1.
  - Simultaneous take_action_ocimem_a and take_action_ocimem_b in IDLE → write executes; address is not reloaded.
- Reset mid-access: reset_n low during RD → avm_read=0 in the same cycle (asynchronous), all outputs 0. After release, state is IDLE and monitor_ready=0.
